// File: rtl/VX_tb_common_pkg.sv
// Shared GPR types and sizing defaults for the GPR shadow monitor and its bench.
package VX_tb_common_pkg;

  localparam int unsigned GPR_NUM_BANKS = 4;
  localparam int unsigned GPR_NUM_SETS  = 32;
  localparam int unsigned GPR_DATA_W    = 32;
  localparam int unsigned GPR_EVT_DEPTH = 4;

  // Index width that never collapses to zero bits for single-entry spaces.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned GPR_BE_W   = GPR_DATA_W / 8;
  localparam int unsigned GPR_SET_W  = idx_w(GPR_NUM_SETS);
  localparam int unsigned GPR_BANK_W = idx_w(GPR_NUM_BANKS);

  typedef logic [GPR_DATA_W-1:0] gpr_entry_t;
  typedef logic [GPR_BE_W-1:0]   gpr_byteen_t;
  typedef logic [GPR_SET_W-1:0]  gpr_set_t;
  typedef logic [GPR_BANK_W-1:0] gpr_bank_t;

  // Write-event record, packed in the same order as the event FIFO payload.
  typedef struct packed {
    gpr_bank_t   bank;
    gpr_set_t    set;
    gpr_entry_t  data;
    gpr_byteen_t byteen;
  } gpr_evt_rec_t;

endpackage

// File: rtl/vx_gpr_shadow_mon_if.sv
// Bus bundle of the GPR shadow monitor: write snoop, shadow read, event stream, overflow.
interface vx_gpr_shadow_mon_if #(
  parameter int unsigned NUM_BANKS = VX_tb_common_pkg::GPR_NUM_BANKS,
  parameter int unsigned NUM_SETS  = VX_tb_common_pkg::GPR_NUM_SETS,
  parameter int unsigned DATA_W    = VX_tb_common_pkg::GPR_DATA_W
);
  import VX_tb_common_pkg::*;

  localparam int unsigned SET_W  = idx_w(NUM_SETS);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned BANK_W = idx_w(NUM_BANKS);

  logic [NUM_BANKS-1:0]             wr_en_i;
  logic [NUM_BANKS-1:0][SET_W-1:0]  wr_set_i;
  logic [NUM_BANKS-1:0][DATA_W-1:0] wr_data_i;
  logic [NUM_BANKS-1:0][BE_W-1:0]   wr_byteen_i;

  logic              rd_en_i;
  logic [BANK_W-1:0] rd_bank_i;
  logic [SET_W-1:0]  rd_set_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;

  logic              evt_valid_o;
  logic              evt_ready_i;
  logic [BANK_W-1:0] evt_bank_o;
  logic [SET_W-1:0]  evt_set_o;
  logic [DATA_W-1:0] evt_data_o;
  logic [BE_W-1:0]   evt_byteen_o;

  logic [NUM_BANKS-1:0] ovf_o;
  logic                 ovf_clr_i;

  modport slave (
    input  wr_en_i, wr_set_i, wr_data_i, wr_byteen_i,
    input  rd_en_i, rd_bank_i, rd_set_i, evt_ready_i, ovf_clr_i,
    output rd_valid_o, rd_data_o, evt_valid_o, evt_bank_o, evt_set_o,
    output evt_data_o, evt_byteen_o, ovf_o
  );

  modport master (
    output wr_en_i, wr_set_i, wr_data_i, wr_byteen_i,
    output rd_en_i, rd_bank_i, rd_set_i, evt_ready_i, ovf_clr_i,
    input  rd_valid_o, rd_data_o, evt_valid_o, evt_bank_o, evt_set_o,
    input  evt_data_o, evt_byteen_o, ovf_o
  );

endinterface

// File: rtl/vx_gpr_evt_fifo.sv
// Per-bank write-event FIFO; a push into a full FIFO is taken only alongside a pop.
module vx_gpr_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  import VX_tb_common_pkg::*;

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned DEPTH_I = DEPTH;
  localparam logic [PTR_W:0] DEPTH_C = DEPTH_I[PTR_W:0];

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state: pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State register with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/vx_gpr_shadow_mon.sv
// GPR shadow monitor: byte-merged shadow copy of each bank plus a round-robin write-event stream.
module vx_gpr_shadow_mon #(
  parameter int unsigned NUM_BANKS = VX_tb_common_pkg::GPR_NUM_BANKS,
  parameter int unsigned NUM_SETS  = VX_tb_common_pkg::GPR_NUM_SETS,
  parameter int unsigned DATA_W    = VX_tb_common_pkg::GPR_DATA_W,
  parameter int unsigned EVT_DEPTH = VX_tb_common_pkg::GPR_EVT_DEPTH
) (
  input logic               clk,
  input logic               reset,
  vx_gpr_shadow_mon_if.slave bus
);
  import VX_tb_common_pkg::*;

  localparam int unsigned SET_W  = idx_w(NUM_SETS);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned BANK_W = idx_w(NUM_BANKS);
  localparam int unsigned REC_W  = BANK_W + SET_W + DATA_W + BE_W;

  function automatic logic [BANK_W-1:0] wrap_idx(input int unsigned v);
    return BANK_W'(v % NUM_BANKS);
  endfunction

  logic [DATA_W-1:0]    shadow_q [NUM_BANKS][NUM_SETS];
  logic [DATA_W-1:0]    shadow_d [NUM_BANKS][NUM_SETS];
  logic [DATA_W-1:0]    merged   [NUM_BANKS];
  logic [REC_W-1:0]     push_rec [NUM_BANKS];
  logic [REC_W-1:0]     head_rec [NUM_BANKS];
  logic [NUM_BANKS-1:0] eff_wr, pop, full, empty, drop;
  logic [NUM_BANKS-1:0] ovf_q, ovf_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [BANK_W-1:0]    rr_q, rr_d, lock_bank_q, lock_bank_d, grant, cand;
  logic                 lock_q, lock_d, arb_found, evt_valid, handshake;

  // Byte-merge each bank's write against its current shadow entry and build the event record.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      eff_wr[b] = bus.wr_en_i[b] && (bus.wr_byteen_i[b] != '0);
      merged[b] = '0;
      for (int k = 0; k < BE_W; k++) begin
        merged[b][8*k +: 8] = bus.wr_byteen_i[b][k] ? bus.wr_data_i[b][8*k +: 8]
                                                    : shadow_q[b][bus.wr_set_i[b]][8*k +: 8];
      end
      push_rec[b] = {BANK_W'(b), bus.wr_set_i[b], merged[b], bus.wr_byteen_i[b]};
    end
  end

  // Shadow update and write-first read of the updated array.
  always_comb begin
    shadow_d = shadow_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (eff_wr[b]) shadow_d[b][bus.wr_set_i[b]] = merged[b];
    end
    rd_valid_d = bus.rd_en_i;
    rd_data_d  = bus.rd_en_i ? shadow_d[bus.rd_bank_i][bus.rd_set_i] : '0;
  end

  // Round-robin grant; once offered and stalled, the grant is locked so a bank
  // that becomes non-empty ahead of it in RR order cannot steal the slot.
  always_comb begin
    evt_valid = |(~empty);
    arb_found = 1'b0;
    cand      = rr_q;
    grant     = rr_q;
    if (lock_q) begin
      grant = lock_bank_q;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        cand = wrap_idx(32'(rr_q) + 32'(i));
        if (!arb_found && !empty[cand]) begin
          grant     = cand;
          arb_found = 1'b1;
        end
      end
    end
    handshake   = evt_valid && bus.evt_ready_i;
    pop         = handshake ? (NUM_BANKS'(1) << grant) : '0;
    lock_d      = evt_valid && !bus.evt_ready_i;
    lock_bank_d = grant;
    rr_d        = handshake ? wrap_idx(32'(grant) + 32'd1) : rr_q;
  end

  // Overflow: a drop sets the sticky flag and beats a same-cycle clear.
  always_comb begin
    drop  = eff_wr & full & ~pop;
    ovf_d = (bus.ovf_clr_i ? '0 : ovf_q) | drop;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_fifo
    vx_gpr_evt_fifo #(.DEPTH(EVT_DEPTH), .W(REC_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (eff_wr[b]),
      .pop_i   (pop[b]),
      .data_i  (push_rec[b]),
      .full_o  (full[b]),
      .empty_o (empty[b]),
      .head_o  (head_rec[b])
    );
  end

  assign bus.evt_valid_o = evt_valid;
  assign {bus.evt_bank_o, bus.evt_set_o, bus.evt_data_o, bus.evt_byteen_o} = head_rec[grant];
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.ovf_o       = ovf_q;

  // State register; writes sampled while reset is high are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int s = 0; s < NUM_SETS; s++) shadow_q[b][s] <= '0;
      ovf_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_bank_q <= '0;
    end else begin
      shadow_q    <= shadow_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_bank_q <= lock_bank_d;
    end
  end

endmodule

// File: tb/tb_vx_gpr_shadow_mon.sv
// Directed bench for vx_gpr_shadow_mon with hand-computed expectations.
module tb_vx_gpr_shadow_mon;
  import VX_tb_common_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  vx_gpr_shadow_mon_if #(.NUM_BANKS(4), .NUM_SETS(32), .DATA_W(32)) bus ();

  vx_gpr_shadow_mon #(.NUM_BANKS(4), .NUM_SETS(32), .DATA_W(32), .EVT_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; single-cycle strobes drop after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.wr_en_i   = '0;
    bus.rd_en_i   = 1'b0;
    bus.ovf_clr_i = 1'b0;
  endtask

  task automatic wr(input int b, input int set, input gpr_entry_t d, input gpr_byteen_t be);
    bus.wr_en_i[b]     = 1'b1;
    bus.wr_set_i[b]    = gpr_set_t'(set);
    bus.wr_data_i[b]   = d;
    bus.wr_byteen_i[b] = be;
  endtask

  task automatic rd(input int b, input int set);
    bus.rd_en_i   = 1'b1;
    bus.rd_bank_i = gpr_bank_t'(b);
    bus.rd_set_i  = gpr_set_t'(set);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.wr_en_i     = '0;
    bus.wr_set_i    = '0;
    bus.wr_data_i   = '0;
    bus.wr_byteen_i = '0;
    bus.rd_en_i     = 1'b0;
    bus.rd_bank_i   = '0;
    bus.rd_set_i    = '0;
    bus.evt_ready_i = 1'b0;
    bus.ovf_clr_i   = 1'b0;

    // Reset state
    do_reset();
    chk("rst_rd_valid", bus.rd_valid_o, 0);
    chk("rst_rd_data", bus.rd_data_o, 0);
    chk("rst_evt_valid", bus.evt_valid_o, 0);
    chk("rst_ovf", bus.ovf_o, 0);

    // Byte merge and event payload
    do_reset();
    bus.evt_ready_i = 1'b1;
    wr(0, 3, 32'hAABB_CCDD, 4'hF);
    tick();
    chk("m_evt_valid", bus.evt_valid_o, 1);
    chk("m_evt_bank", bus.evt_bank_o, 0);
    chk("m_evt_set", bus.evt_set_o, 3);
    chk("m_evt_data1", bus.evt_data_o, 32'hAABB_CCDD);
    wr(0, 3, 32'h1122_3344, 4'h5);
    tick();
    chk("m_evt_data2", bus.evt_data_o, 32'hAA22_CC44);
    chk("m_evt_be2", bus.evt_byteen_o, 4'h5);
    rd(0, 3);
    tick();
    chk("m_rd_valid", bus.rd_valid_o, 1);
    chk("m_rd_data", bus.rd_data_o, 32'hAA22_CC44);
    chk("m_evt_drained", bus.evt_valid_o, 0);
    wr(0, 4, 32'h5555_5555, 4'h0);
    tick();
    chk("m_rd_valid_idle", bus.rd_valid_o, 0);
    chk("m_be0_no_evt", bus.evt_valid_o, 0);
    rd(0, 4);
    tick();
    chk("m_be0_no_write", bus.rd_data_o, 0);

    // All banks in one cycle, round-robin from bank 0
    do_reset();
    bus.evt_ready_i = 1'b1;
    for (int b = 0; b < 4; b++) wr(b, 0, 32'h1000_0000 + 32'(b), 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rr_valid", bus.evt_valid_o, 1);
      chk("rr_bank", bus.evt_bank_o, i);
      chk("rr_data", bus.evt_data_o, 32'h1000_0000 + 32'(i));
      tick();
    end
    chk("rr_empty", bus.evt_valid_o, 0);

    // Stalled grant stays on bank1 while bank0 fills
    do_reset();
    bus.evt_ready_i = 1'b0;
    wr(1, 2, 32'hB1B1_0001, 4'hF);
    tick();
    chk("st_bank_first", bus.evt_bank_o, 1);
    wr(0, 2, 32'hB0B0_0000, 4'hF);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("st_valid", bus.evt_valid_o, 1);
      chk("st_bank", bus.evt_bank_o, 1);
      chk("st_data", bus.evt_data_o, 32'hB1B1_0001);
      tick();
    end
    bus.evt_ready_i = 1'b1;
    chk("st_bank_hs", bus.evt_bank_o, 1);
    tick();
    chk("st_next_bank", bus.evt_bank_o, 0);
    chk("st_next_data", bus.evt_data_o, 32'hB0B0_0000);
    tick();
    chk("st_empty", bus.evt_valid_o, 0);

    // Overflow on bank2, clear, set-beats-clear, full with pop
    do_reset();
    bus.evt_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(2, i, 32'h2000_0000 + 32'(i), 4'hF);
      tick();
      chk("ov_flag", bus.ovf_o, (i == 4) ? 4'b0100 : 4'b0000);
    end
    chk("ov_head_set", bus.evt_set_o, 0);
    chk("ov_head_data", bus.evt_data_o, 32'h2000_0000);
    bus.ovf_clr_i = 1'b1;
    tick();
    chk("ov_clear", bus.ovf_o, 0);
    wr(2, 10, 32'h2000_000A, 4'hF);
    bus.ovf_clr_i = 1'b1;
    tick();
    chk("ov_set_wins", bus.ovf_o, 4'b0100);
    bus.ovf_clr_i = 1'b1;
    tick();
    chk("ov_clear2", bus.ovf_o, 0);
    rd(2, 4);
    tick();
    chk("ov_shadow4", bus.rd_data_o, 32'h2000_0004);
    rd(2, 10);
    tick();
    chk("ov_shadow10", bus.rd_data_o, 32'h2000_000A);
    bus.evt_ready_i = 1'b1;
    wr(2, 9, 32'h2000_0009, 4'hF);
    tick();
    chk("ov_full_pop", bus.ovf_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ov_order_set", bus.evt_set_o, (i == 3) ? 9 : i + 1);
      chk("ov_order_data", bus.evt_data_o, 32'h2000_0000 + 32'((i == 3) ? 9 : i + 1));
      tick();
    end
    chk("ov_drained", bus.evt_valid_o, 0);

    // Same-edge write and read returns merged data
    do_reset();
    wr(1, 7, 32'hDEAD_BEEF, 4'h3);
    rd(1, 7);
    tick();
    chk("wf_rd_valid", bus.rd_valid_o, 1);
    chk("wf_rd_data", bus.rd_data_o, 32'h0000_BEEF);

    // Reset with queued events
    do_reset();
    bus.evt_ready_i = 1'b0;
    wr(0, 1, 32'h0A0A_0A0A, 4'hF);
    wr(1, 1, 32'h1B1B_1B1B, 4'hF);
    wr(3, 1, 32'h3D3D_3D3D, 4'hF);
    tick();
    chk("rq_valid", bus.evt_valid_o, 1);
    reset = 1'b1;
    wr(2, 5, 32'hFFFF_FFFF, 4'hF);
    rd(0, 1);
    tick();
    reset = 1'b0;
    chk("rq_evt_cleared", bus.evt_valid_o, 0);
    chk("rq_rd_dropped", bus.rd_valid_o, 0);
    rd(0, 1);
    tick();
    chk("rq_rd_valid", bus.rd_valid_o, 1);
    chk("rq_shadow0", bus.rd_data_o, 0);
    rd(2, 5);
    tick();
    chk("rq_wr_ignored", bus.rd_data_o, 0);
    chk("rq_no_evt", bus.evt_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_gpr_shadow_mon.md
VX_GPR_SHADOW_MON -- requirements
Module: vx_gpr_shadow_mon

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of GPR banks monitored (>=1).
REQ-002 SHALL have parameter NUM_SETS, default 32: entries per bank (power of 2); SET_W = $clog2(NUM_SETS).
REQ-003 SHALL have parameter DATA_W, default 32: entry width in bits, multiple of 8; BE_W = DATA_W/8.
REQ-004 SHALL have parameter EVT_DEPTH, default 4: per-bank event FIFO depth (power of 2, >=2).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 wr_en_i  in  NUM_BANKS  per-bank write strobe.
REQ-008 wr_set_i  in  NUM_BANKS x SET_W  per-bank target set.
REQ-009 wr_data_i  in  NUM_BANKS x DATA_W  per-bank write data.
REQ-010 wr_byteen_i  in  NUM_BANKS x BE_W  per-bank byte enables.
REQ-011 rd_en_i / rd_bank_i / rd_set_i  in  1 / $clog2(NUM_BANKS) / SET_W  shadow read request.
REQ-012 rd_valid_o / rd_data_o  out  1 / DATA_W  registered read response.
REQ-013 evt_valid_o, evt_ready_i  out/in  1 each  write-event stream handshake.
REQ-014 evt_bank_o / evt_set_o / evt_data_o / evt_byteen_o  out  bank idx / SET_W / DATA_W / BE_W  event payload.
REQ-015 ovf_o  out  NUM_BANKS  sticky per-bank event-drop flag; ovf_clr_i  in  1  clears all flags.

Function
REQ-016 Shadow write: when wr_en_i[b] and byteen nonzero, each enabled byte of shadow[b][set] SHALL take wr_data_i byte; disabled bytes retain value; visible next cycle.
REQ-017 wr_en_i[b] with byteen==0 SHALL update nothing and generate no event.
REQ-018 All banks SHALL accept writes concurrently, one per bank per cycle; banks independent.
REQ-019 Each effective write SHALL push {bank, set, post-merge full entry, byteen} into bank b's FIFO in the same edge.
REQ-020 Push to full FIFO with no same-cycle pop from that bank SHALL be dropped and set ovf_o[b]; shadow still updated.
REQ-021 Push to full FIFO with same-cycle pop of that bank SHALL be accepted, no overflow.
REQ-022 Set-on-overflow SHALL win over ovf_clr_i in the same cycle.
REQ-023 Event output: round-robin over non-empty FIFOs; evt_valid_o asserts when any FIFO non-empty; payload = granted FIFO head.
REQ-024 While evt_valid_o && !evt_ready_i, grant and payload SHALL stay stable.
REQ-025 On handshake, granted FIFO pops and RR pointer moves to granted bank+1 (mod NUM_BANKS).
REQ-026 Minimum write-to-event latency: write at edge N -> evt_valid_o high in cycle N+1.
REQ-027 Per-bank event order SHALL equal write order.
REQ-028 Read: rd_en_i at edge N -> rd_valid_o=1, rd_data_o in cycle N+1; rd_valid_o=0 otherwise.
REQ-029 Read of an entry written at the same edge SHALL return post-merge data (write-first).

Reset
REQ-030 On reset: all shadow entries 0, FIFOs empty, RR pointer 0, ovf_o=0, evt_valid_o=0, rd_valid_o=0, rd_data_o=0.
REQ-031 Reset mid-operation SHALL discard queued events and in-flight reads; writes sampled with reset high ignored.

Structure
REQ-032 Entry, byteen and event-record typedefs SHALL live in VX_tb_common_pkg alongside existing GPR types.
REQ-033 Per-bank FIFO SHALL be one sub-module, vx_gpr_evt_fifo (push, pop, full, empty, head), instantiated NUM_BANKS times.

Verification
REQ-034 Bank0 set3 write 0xAABBCCDD be=0xF, then data 0x11223344 be=0x5 -> read returns 0xAA22CC44; two events, second evt_data=0xAA22CC44.
REQ-035 All 4 banks write same cycle, ready=1 -> events emitted banks 0,1,2,3 on consecutive cycles starting N+1.
REQ-036 Hold evt_ready_i=0, 5 writes to bank2 (depth 4) -> 4 queued, ovf_o=4'b0100; then ovf_clr_i -> 0.
REQ-037 evt_ready_i=0 for 3 cycles with bank1 head pending while bank0 becomes non-empty -> payload stays bank1 until handshake.
REQ-038 Same-edge write (be=0x3, 0x0000BEEF) and read to bank1 set7 over 0 -> rd_data_o=0x0000BEEF next cycle.
REQ-039 Reset asserted with 3 queued events -> next cycle evt_valid_o=0, reads return 0.
